// File: rtl/i2c_init_sequencer_pkg.sv
// Shared types for the I2C init sequencer: ROM opcodes, error codes and FSM states.
package i2c_init_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_END    = 2'b00,
        OP_WRITE  = 2'b01,
        OP_DELAY  = 2'b10,
        OP_VERIFY = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_VERIFY  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_RETRY,
        S_DLY,
        S_FIN,
        S_ERR
    } state_e;

    localparam int unsigned RETRY_WIDTH  = 8;
    localparam int unsigned PRE_WIDTH    = 16;
    localparam int unsigned MIN_TMR_BITS = 24;

endpackage

// File: rtl/i2c_init_sequencer_timer.sv
// Loadable down-counter with prescaler; o_expire is high once i_count * i_prescale cycles have elapsed.
module i2c_seq_timer #(
    parameter int unsigned CNT_WIDTH = 24,
    parameter int unsigned PRE_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_count,
    input  logic [PRE_WIDTH-1:0] i_prescale,
    output logic                 o_expire
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [PRE_WIDTH-1:0] r_pre;
    logic [PRE_WIDTH-1:0] r_reload;
    logic                 r_active;
    logic [PRE_WIDTH-1:0] w_reload;

    // A prescale of 0 behaves like 1 so the counter can never stall.
    assign w_reload = (i_prescale == '0) ? '0 : (i_prescale - 1'b1);
    assign o_expire = r_active && (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_pre    <= '0;
            r_reload <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= i_count;
            r_pre    <= w_reload;
            r_reload <= w_reload;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else if (r_pre == '0) begin
                r_cnt <= r_cnt - 1'b1;
                r_pre <= r_reload;
            end else begin
                r_pre <= r_pre - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks a ROM command table (WRITE / VERIFY / DELAY / END) and drives one i2c_master
// to configure a slave after power-up, with NACK retries and a bus-hang timeout.
module i2c_init_sequencer
    import i2c_init_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_BYTES     = 1,
    parameter int unsigned DATA_BYTES     = 2,
    parameter int unsigned REG_ADDR_WIDTH = 8 * ADDR_BYTES,
    parameter int unsigned ST_WIDTH       = 1 + ADDR_BYTES + DATA_BYTES,
    parameter int unsigned CMD_WIDTH      = 2 + REG_ADDR_WIDTH + 8 * DATA_BYTES,
    parameter int unsigned CMD_ADDR_WIDTH = 8,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter logic [15:0] DELAY_TICK     = 16'd50000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [6:0]                chip_addr,
    output logic [CMD_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CMD_WIDTH-1:0]      cmd_data,
    output logic [6:0]                i2c_chip_addr,
    output logic [REG_ADDR_WIDTH-1:0] i2c_reg_addr,
    output logic [8*DATA_BYTES-1:0]   i2c_wdata,
    output logic                      i2c_write_en,
    output logic                      i2c_read_en,
    output logic                      i2c_write_mode,
    input  logic [8*DATA_BYTES-1:0]   i2c_rdata,
    input  logic [ST_WIDTH-1:0]       i2c_status,
    input  logic                      i2c_done,
    input  logic                      i2c_busy,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [CMD_ADDR_WIDTH-1:0] err_index
);

    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned TW = (DW > MIN_TMR_BITS) ? DW : MIN_TMR_BITS;

    state_e                   r_state;
    logic [CMD_WIDTH-1:0]     r_cmd;
    logic [CMD_ADDR_WIDTH-1:0] r_index;
    logic [RETRY_WIDTH-1:0]   r_retry;
    logic [6:0]               r_chip;
    logic [REG_ADDR_WIDTH-1:0] r_reg_addr;
    logic [DW-1:0]            r_wdata;
    logic                     r_write_en;
    logic                     r_read_en;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_error;
    err_e                     r_err_code;
    logic [CMD_ADDR_WIDTH-1:0] r_err_index;

    op_e                      w_op_in;
    op_e                      w_op;
    logic [REG_ADDR_WIDTH-1:0] w_reg;
    logic [DW-1:0]            w_data;
    logic                     w_last;
    logic                     w_tmr_load;
    logic [TW-1:0]            w_tmr_count;
    logic [PRE_WIDTH-1:0]     w_tmr_pre;
    logic                     w_tmr_expire;

    // ROM data is only valid in DECODE, so the opcode is decoded straight from cmd_data there.
    assign w_op_in = op_e'(cmd_data[CMD_WIDTH-1 -: 2]);
    assign w_op    = op_e'(r_cmd[CMD_WIDTH-1 -: 2]);
    assign w_reg   = r_cmd[DW +: REG_ADDR_WIDTH];
    assign w_data  = r_cmd[DW-1:0];
    assign w_last  = (r_index == '1);

    assign cmd_addr       = r_index;
    assign i2c_chip_addr  = r_chip;
    assign i2c_reg_addr   = r_reg_addr;
    assign i2c_wdata      = r_wdata;
    assign i2c_write_en   = r_write_en;
    assign i2c_read_en    = r_read_en;
    assign i2c_write_mode = 1'b0;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign err_code       = r_err_code;
    assign err_index      = r_err_index;

    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_count = '0;
        w_tmr_pre   = '0;
        if (r_state == S_DECODE && w_op_in == OP_DELAY) begin
            w_tmr_load  = 1'b1;
            w_tmr_count = TW'(cmd_data[DW-1:0]);
            w_tmr_pre   = DELAY_TICK;
        end else if (r_state == S_ISSUE && !i2c_busy) begin
            w_tmr_load  = 1'b1;
            w_tmr_count = TW'(TIMEOUT_CYCLES);
            w_tmr_pre   = PRE_WIDTH'(1);
        end
    end

    i2c_seq_timer #(
        .CNT_WIDTH (TW),
        .PRE_WIDTH (PRE_WIDTH)
    ) u_timer (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_load     (w_tmr_load),
        .i_count    (w_tmr_count),
        .i_prescale (w_tmr_pre),
        .o_expire   (w_tmr_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_index     <= '0;
            r_retry     <= '0;
            r_chip      <= '0;
            r_reg_addr  <= '0;
            r_wdata     <= '0;
            r_write_en  <= 1'b0;
            r_read_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_index <= '0;
        end else begin
            r_write_en <= 1'b0;
            r_read_en  <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !i2c_busy) begin
                        r_error     <= 1'b0;
                        r_err_code  <= ERR_NONE;
                        r_err_index <= '0;
                        r_index     <= '0;
                        r_chip      <= chip_addr;
                        r_busy      <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_cmd   <= cmd_data;
                    r_retry <= '0;
                    case (w_op_in)
                        OP_END:   r_state <= S_FIN;
                        OP_DELAY: r_state <= S_DLY;
                        default:  r_state <= S_ISSUE;
                    endcase
                end
                S_ISSUE: begin
                    if (!i2c_busy) begin
                        r_reg_addr <= w_reg;
                        r_wdata    <= w_data;
                        r_write_en <= (w_op == OP_WRITE);
                        r_read_en  <= (w_op == OP_VERIFY);
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i2c_done) begin
                        if (w_op == OP_WRITE && |i2c_status) begin
                            r_state <= S_RETRY;
                        end else if (w_op == OP_VERIFY && i2c_rdata != w_data) begin
                            r_err_code  <= ERR_VERIFY;
                            r_err_index <= r_index;
                            r_state     <= S_ERR;
                        end else if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end else if (w_tmr_expire) begin
                        r_err_code  <= ERR_TIMEOUT;
                        r_err_index <= r_index;
                        r_state     <= S_ERR;
                    end
                end
                S_RETRY: begin
                    if (r_retry < RETRY_WIDTH'(MAX_RETRIES)) begin
                        r_retry <= r_retry + 1'b1;
                        r_state <= S_ISSUE;
                    end else begin
                        r_err_code  <= ERR_NACK;
                        r_err_index <= r_index;
                        r_state     <= S_ERR;
                    end
                end
                S_DLY: begin
                    // The last table entry finishes the run instead of wrapping to entry 0.
                    if (w_tmr_expire) begin
                        if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_error <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Self-checking bench: random command tables, a behavioural i2c_master/slave model, and a
// table-walking reference model that predicts the frames issued and the final status.
module tb_i2c_init_sequencer;

    localparam int MAXR = 3;
    localparam int TICK = 10;
    localparam int TMO  = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  chip_addr = '0;
    logic [7:0]  cmd_addr;
    logic [25:0] cmd_data = '0;
    logic [6:0]  i2c_chip_addr;
    logic [7:0]  i2c_reg_addr;
    logic [15:0] i2c_wdata;
    logic        i2c_write_en, i2c_read_en, i2c_write_mode;
    logic [15:0] i2c_rdata = '0;
    logic [3:0]  i2c_status = '0;
    logic        i2c_done = 1'b0;
    logic        i2c_busy = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [7:0]  err_index;

    i2c_init_sequencer #(
        .MAX_RETRIES    (MAXR),
        .DELAY_TICK     (16'(TICK)),
        .TIMEOUT_CYCLES (24'(TMO))
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .start          (start),
        .chip_addr      (chip_addr),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .i2c_chip_addr  (i2c_chip_addr),
        .i2c_reg_addr   (i2c_reg_addr),
        .i2c_wdata      (i2c_wdata),
        .i2c_write_en   (i2c_write_en),
        .i2c_read_en    (i2c_read_en),
        .i2c_write_mode (i2c_write_mode),
        .i2c_rdata      (i2c_rdata),
        .i2c_status     (i2c_status),
        .i2c_done       (i2c_done),
        .i2c_busy       (i2c_busy),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_code       (err_code),
        .err_index      (err_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [25:0] rom [256];
    always @(posedge clk) cmd_data <= rom[cmd_addr];

    int          nacks [256];
    logic [15:0] mxor  [256];
    int          hang_idx;
    int          lat_fix;

    typedef struct {
        bit        rd;
        bit [7:0]  addr;
        bit [15:0] data;
        bit [3:0]  status;
        bit [15:0] rdata;
        bit        hang;
    } frame_t;

    frame_t exp_q[$];
    int     exp_total;
    bit     e_err;
    int     e_code;
    int     e_idx;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: walk the table by its rules and list every frame the slave will see.
    task automatic build_model();
        bit [1:0]  op;
        bit [7:0]  a;
        bit [15:0] d;
        frame_t    f;
        exp_q.delete();
        e_err = 0; e_code = 0; e_idx = 0;
        for (int i = 0; i < 256; i++) begin
            {op, a, d} = rom[i];
            if (op == 2'b00) return;
            if (op == 2'b10) continue;
            f.rd = (op == 2'b11); f.addr = a; f.data = d; f.hang = 0; f.rdata = 16'h0;
            if (i == hang_idx) begin
                f.hang = 1; f.status = 0;
                exp_q.push_back(f);
                e_err = 1; e_code = 3; e_idx = i;
                return;
            end
            if (op == 2'b01) begin
                for (int t = 0; t <= MAXR; t++) begin
                    f.status = (t < nacks[i]) ? 4'($urandom_range(1, 15)) : 4'h0;
                    exp_q.push_back(f);
                    if (f.status == 0) break;
                end
                if (nacks[i] > MAXR) begin
                    e_err = 1; e_code = 1; e_idx = i;
                    return;
                end
            end else begin
                f.status = 4'($urandom_range(0, 15));
                f.rdata  = d ^ mxor[i];
                exp_q.push_back(f);
                if (mxor[i] != 0) begin
                    e_err = 1; e_code = 2; e_idx = i;
                    return;
                end
            end
        end
    endtask

    // Behavioural i2c_master + slave: answers each request with the next modelled frame.
    int     m_cnt = 0;
    bit     m_abort = 0;
    int     m_frames = 0;
    int     m_strobe_cyc = 0;
    bit     m_prev_stb = 0;
    frame_t m_cur;

    initial begin : master_bfm
        forever begin
            @(posedge clk); #1;
            i2c_done = 1'b0;
            if (m_abort) begin
                m_abort = 0; m_cnt = 0; i2c_busy = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    i2c_done = 1'b1; i2c_busy = 1'b0;
                    i2c_status = m_cur.status; i2c_rdata = m_cur.rdata;
                end
            end
            if (rst_n && (i2c_write_en || i2c_read_en)) begin
                check("stb_while_busy", i2c_busy, 0);
                check("stb_width", m_prev_stb, 0);
                check("stb_both", i2c_write_en && i2c_read_en, 0);
                check("write_mode", i2c_write_mode, 0);
                check("chip_addr", i2c_chip_addr, chip_addr);
                m_frames++;
                m_strobe_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_frame", m_frames, exp_total);
                    m_cur.status = 0; m_cur.rdata = 0; m_cur.hang = 0;
                end else begin
                    m_cur = exp_q.pop_front();
                    check("frame_rd", i2c_read_en, m_cur.rd);
                    check("frame_addr", i2c_reg_addr, m_cur.addr);
                    check("frame_data", i2c_wdata, m_cur.data);
                end
                i2c_busy = 1'b1;
                m_cnt = m_cur.hang ? 0 : ((lat_fix != 0) ? lat_fix : $urandom_range(2, 8));
            end
            m_prev_stb = i2c_write_en || i2c_read_en;
        end
    end

    task automatic clear_table();
        for (int i = 0; i < 256; i++) begin
            rom[i] = '0; nacks[i] = 0; mxor[i] = '0;
        end
        hang_idx = -1;
        lat_fix = 0;
    endtask

    task automatic settle_master();
        m_abort = 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_scn(input string tag, output int lat, output int t_end);
        int t0;
        bit got;
        build_model();
        exp_total = exp_q.size();
        m_frames = 0;
        chip_addr = 7'($urandom);
        @(posedge clk); #1;
        start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_busy_running"}, busy, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 20000 && !got; i++) begin
            if (done || error) got = 1;
            else begin @(posedge clk); #1; end
        end
        check({tag, "_completed"}, got, 1);
        t_end = cyc;
        lat = t_end - t0;
        check({tag, "_done"}, done, !e_err);
        check({tag, "_error"}, error, e_err);
        check({tag, "_err_code"}, err_code, e_code);
        check({tag, "_err_index"}, err_index, e_idx);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_frames"}, m_frames, exp_total);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_error_sticky"}, error, e_err);
        if (e_err) settle_master();
    endtask

    initial begin : main
        int lat, lat0, tend, n;
        bit got;
        clear_table();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        check("rst_cmd_addr", cmd_addr, 0);
        check("rst_strobes", {i2c_write_en, i2c_read_en}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        clear_table();
        rom[0] = {2'b01, 8'h10, 16'hA5A5};
        run_scn("wr_single", lat, tend);

        clear_table();
        rom[0] = {2'b01, 8'h10, 16'hA5A5};
        nacks[0] = 2;
        run_scn("wr_nack2", lat, tend);

        clear_table();
        rom[0] = {2'b01, 8'h10, 16'hA5A5};
        nacks[0] = 99;
        run_scn("wr_nack_all", lat, tend);

        clear_table();
        rom[0] = {2'b10, 8'h00, 16'd0};
        run_scn("dly0", lat0, tend);
        n = $urandom_range(1, 5);
        clear_table();
        rom[0] = {2'b10, 8'h00, 16'(n)};
        run_scn("dlyN", lat, tend);
        check("delay_length", lat - lat0, n * TICK);

        clear_table();
        rom[0] = {2'b11, 8'h20, 16'h1234};
        mxor[0] = 16'h0001;
        run_scn("vfy_mismatch", lat, tend);

        clear_table();
        rom[0] = {2'b11, 8'h20, 16'h1234};
        rom[1] = {2'b01, 8'h21, 16'h0042};
        hang_idx = 1;
        run_scn("timeout", lat, tend);
        check("timeout_latency", (tend - m_strobe_cyc >= TMO) && (tend - m_strobe_cyc <= TMO + 4), 1);

        clear_table();
        for (int i = 0; i < 255; i++) rom[i] = {2'b10, 8'h00, 16'd0};
        rom[255] = {2'b01, 8'h7E, 16'hBEEF};
        run_scn("last_entry", lat, tend);

        for (int s = 0; s < 20; s++) begin
            int len;
            clear_table();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 5)      rom[i] = {2'b01, 8'($urandom), 16'($urandom)};
                else if (r < 7) rom[i] = {2'b11, 8'($urandom), 16'($urandom)};
                else            rom[i] = {2'b10, 8'($urandom), 16'($urandom_range(0, 2))};
                nacks[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
                mxor[i]  = ($urandom_range(0, 4) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            end
            if ($urandom_range(0, 7) == 0) hang_idx = $urandom_range(0, len - 1);
            run_scn($sformatf("rnd%0d", s), lat, tend);
        end

        // Reset while a write request strobe is high.
        clear_table();
        rom[0] = {2'b01, 8'h33, 16'h5A5A};
        lat_fix = 30;
        build_model();
        exp_total = exp_q.size();
        m_frames = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #2;
            if (i2c_write_en) got = 1;
        end
        check("rst_mid_strobe_seen", got, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_write_en", i2c_write_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_outputs", {done, error, err_code, err_index, cmd_addr, i2c_reg_addr, i2c_wdata}, 0);
        check("rst_mid_chip", i2c_chip_addr, 0);
        exp_q.delete();
        settle_master();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        clear_table();
        rom[0] = {2'b01, 8'h44, 16'h1357};
        rom[1] = {2'b11, 8'h44, 16'h1357};
        run_scn("after_reset", lat, tend);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
